// File: rtl/jlut_prog.sv
// Programmable jump-target lookup table with a return-address stack.
// Resolves JUMP/CALL/RET requests into a registered target one cycle later.
module jlut_prog #(
    parameter  int PTR_W       = 5,
    parameter  int PC_W        = 12,
    parameter  int ENTRIES     = 32,
    parameter  int STACK_DEPTH = 4,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               WrEn,
    input  logic [PTR_W-1:0]   WrPtr,
    input  logic [PC_W-1:0]    WrData,
    input  logic               WrMode,
    input  logic               Req,
    input  logic [1:0]         Op,
    input  logic [PTR_W-1:0]   Jptr,
    input  logic [PC_W-1:0]    PC,
    output logic               Valid,
    output logic [PC_W-1:0]    Jump,
    output logic               Err,
    output logic [DEPTH_W-1:0] Depth
);

    localparam int EW = PC_W + 1;

    typedef enum logic [1:0] {
        OP_JUMP = 2'b00,
        OP_CALL = 2'b01,
        OP_RET  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    // Entry layout: {mode, value}; mode 1 means value is a signed PC offset.
    logic [EW-1:0]      tbl_q [ENTRIES];
    logic [EW-1:0]      tbl_d [ENTRIES];
    logic [PC_W-1:0]    stk_q [STACK_DEPTH];
    logic [PC_W-1:0]    stk_d [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [PC_W-1:0]    jump_q, jump_d;

    logic               wr_ok;
    logic               jptr_ok;
    logic               stk_full;
    logic               stk_empty;
    logic [EW-1:0]      entry;
    logic [PC_W-1:0]    target;
    logic [PC_W-1:0]    top;

    assign wr_ok     = WrEn && (32'(WrPtr) < 32'(ENTRIES));
    assign jptr_ok   = 32'(Jptr) < 32'(ENTRIES);
    assign stk_full  = depth_q == DEPTH_W'(STACK_DEPTH);
    assign stk_empty = depth_q == '0;

    // Table read with write-first bypass for a same-edge write to the same index.
    always_comb begin
        entry = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (Jptr == PTR_W'(i)) begin
                entry = tbl_q[i];
            end
        end
        if (wr_ok && (WrPtr == Jptr)) begin
            entry = {WrMode, WrData};
        end
    end

    always_comb begin
        if (entry[PC_W]) begin
            target = PC + entry[PC_W-1:0];
        end else begin
            target = entry[PC_W-1:0];
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                top = stk_q[i];
            end
        end
    end

    always_comb begin
        tbl_d   = tbl_q;
        stk_d   = stk_q;
        depth_d = depth_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        jump_d  = jump_q;

        if (wr_ok) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (WrPtr == PTR_W'(i)) begin
                    tbl_d[i] = {WrMode, WrData};
                end
            end
        end

        if (Req) begin
            case (op_e'(Op))
                OP_JUMP: begin
                    if (jptr_ok) begin
                        jump_d  = target;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_CALL: begin
                    if (jptr_ok && !stk_full) begin
                        jump_d  = target;
                        valid_d = 1'b1;
                        for (int i = 0; i < STACK_DEPTH; i++) begin
                            if (depth_q == DEPTH_W'(i)) begin
                                stk_d[i] = PC + PC_W'(1);
                            end
                        end
                        depth_d = depth_q + DEPTH_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!stk_empty) begin
                        jump_d  = top;
                        valid_d = 1'b1;
                        depth_d = depth_q - DEPTH_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= '0;
            end
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_q[i] <= '0;
            end
            depth_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            jump_q  <= '0;
        end else begin
            tbl_q   <= tbl_d;
            stk_q   <= stk_d;
            depth_q <= depth_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            jump_q  <= jump_d;
        end
    end

    assign Valid = valid_q;
    assign Err   = err_q;
    assign Jump  = jump_q;
    assign Depth = depth_q;

endmodule

// File: tb/tb_jlut_prog.sv
// Directed bench for jlut_prog: expected outputs are queued when a request is
// driven and popped one cycle later when the registered result is sampled.
module tb_jlut_prog;

    localparam int PTR_W   = 5;
    localparam int PC_W    = 12;
    localparam int ENTRIES = 20;
    localparam int SD      = 4;
    localparam int DW      = $clog2(SD + 1);
    localparam int XW      = 2 + PC_W + DW;

    logic             Clk;
    logic             Reset;
    logic             WrEn;
    logic [PTR_W-1:0] WrPtr;
    logic [PC_W-1:0]  WrData;
    logic             WrMode;
    logic             Req;
    logic [1:0]       Op;
    logic [PTR_W-1:0] Jptr;
    logic [PC_W-1:0]  PC;
    logic             Valid;
    logic [PC_W-1:0]  Jump;
    logic             Err;
    logic [DW-1:0]    Depth;

    logic [XW-1:0] exp_q[$];
    string         tag_q[$];
    int            pass_cnt  = 0;
    int            total_cnt = 0;

    jlut_prog #(
        .PTR_W(PTR_W), .PC_W(PC_W), .ENTRIES(ENTRIES), .STACK_DEPTH(SD)
    ) dut (
        .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrPtr(WrPtr), .WrData(WrData),
        .WrMode(WrMode), .Req(Req), .Op(Op), .Jptr(Jptr), .PC(PC),
        .Valid(Valid), .Jump(Jump), .Err(Err), .Depth(Depth)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [PC_W-1:0] got, input logic [PC_W-1:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic chk_now(input string tag, input logic ev, input logic ee,
                           input logic [PC_W-1:0] ej, input logic [DW-1:0] ed);
        chk({tag, ".valid"}, PC_W'(Valid), PC_W'(ev));
        chk({tag, ".err"},   PC_W'(Err),   PC_W'(ee));
        chk({tag, ".jump"},  Jump,         ej);
        chk({tag, ".depth"}, PC_W'(Depth), PC_W'(ed));
        chk({tag, ".excl"},  PC_W'(Valid & Err), '0);
    endtask

    task automatic pop_and_check();
        logic [XW-1:0] e;
        string         t;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $error("FAIL scoreboard_empty got=0 exp=1");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk_now(t, e[XW-1], e[XW-2], e[DW +: PC_W], e[DW-1:0]);
        end
    endtask

    // One clock step: drive inputs, queue the expectation, sample #1 after the edge.
    task automatic step(input logic req, input logic [1:0] op, input logic [PTR_W-1:0] jp,
                        input logic [PC_W-1:0] pc, input logic we, input logic [PTR_W-1:0] wp,
                        input logic [PC_W-1:0] wd, input logic wm,
                        input logic ev, input logic ee, input logic [PC_W-1:0] ej,
                        input logic [DW-1:0] ed, input string tag);
        Req = req; Op = op; Jptr = jp; PC = pc;
        WrEn = we; WrPtr = wp; WrData = wd; WrMode = wm;
        exp_q.push_back({ev, ee, ej, ed});
        tag_q.push_back(tag);
        @(posedge Clk);
        #1;
        Req = 1'b0; WrEn = 1'b0;
        pop_and_check();
    endtask

    task automatic wr(input logic [PTR_W-1:0] wp, input logic [PC_W-1:0] wd, input logic wm,
                      input logic [PC_W-1:0] ej, input logic [DW-1:0] ed, input string tag);
        step(1'b0, 2'b00, '0, '0, 1'b1, wp, wd, wm, 1'b0, 1'b0, ej, ed, tag);
    endtask

    task automatic rq(input logic [1:0] op, input logic [PTR_W-1:0] jp, input logic [PC_W-1:0] pc,
                      input logic ev, input logic ee, input logic [PC_W-1:0] ej,
                      input logic [DW-1:0] ed, input string tag);
        step(1'b1, op, jp, pc, 1'b0, '0, '0, 1'b0, ev, ee, ej, ed, tag);
    endtask

    initial begin
        Reset = 1'b0; WrEn = 1'b0; WrPtr = '0; WrData = '0; WrMode = 1'b0;
        Req = 1'b0; Op = 2'b00; Jptr = '0; PC = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk_now("reset", 1'b0, 1'b0, 12'h000, 3'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        rq(2'b00, 5'd7, 12'd0, 1'b1, 1'b0, 12'd0, 3'd0, "jump_cleared");
        wr(5'd3, 12'd196, 1'b0, 12'd0, 3'd0, "wr3");
        rq(2'b00, 5'd3, 12'd100, 1'b1, 1'b0, 12'd196, 3'd0, "jump_abs");
        wr(5'd4, 12'hFFC, 1'b1, 12'd196, 3'd0, "wr4");
        rq(2'b00, 5'd4, 12'd2, 1'b1, 1'b0, 12'hFFE, 3'd0, "jump_rel_wrap");
        step(1'b1, 2'b00, 5'd5, 12'd0, 1'b1, 5'd5, 12'd86, 1'b0,
             1'b1, 1'b0, 12'd86, 3'd0, "bypass");
        wr(5'd19, 12'h123, 1'b0, 12'd86, 3'd0, "wr_last");
        rq(2'b00, 5'd19, 12'd0, 1'b1, 1'b0, 12'h123, 3'd0, "jump_last");

        wr(5'd1, 12'd9, 1'b0, 12'h123, 3'd0, "wr1");
        rq(2'b01, 5'd1, 12'd10, 1'b1, 1'b0, 12'd9, 3'd1, "call1");
        rq(2'b01, 5'd1, 12'd20, 1'b1, 1'b0, 12'd9, 3'd2, "call2");
        rq(2'b01, 5'd1, 12'd30, 1'b1, 1'b0, 12'd9, 3'd3, "call3");
        rq(2'b01, 5'd1, 12'd40, 1'b1, 1'b0, 12'd9, 3'd4, "call4");
        rq(2'b01, 5'd1, 12'd50, 1'b0, 1'b1, 12'd9, 3'd4, "call_full");
        rq(2'b10, 5'd0, 12'd0, 1'b1, 1'b0, 12'd41, 3'd3, "ret1");
        rq(2'b10, 5'd0, 12'd0, 1'b1, 1'b0, 12'd31, 3'd2, "ret2");
        rq(2'b10, 5'd0, 12'd0, 1'b1, 1'b0, 12'd21, 3'd1, "ret3");
        rq(2'b10, 5'd0, 12'd0, 1'b1, 1'b0, 12'd11, 3'd0, "ret4");
        rq(2'b10, 5'd0, 12'd0, 1'b0, 1'b1, 12'd11, 3'd0, "ret_empty");

        wr(5'd6, 12'd5, 1'b1, 12'd11, 3'd0, "wr6_rel");
        rq(2'b01, 5'd6, 12'hFFF, 1'b1, 1'b0, 12'h004, 3'd1, "call_rel_wrap");
        rq(2'b10, 5'd0, 12'd0, 1'b1, 1'b0, 12'h000, 3'd0, "ret_pc_wrap");

        rq(2'b00, 5'd25, 12'd0, 1'b0, 1'b1, 12'd0, 3'd0, "jump_oob");
        rq(2'b01, 5'd20, 12'd0, 1'b0, 1'b1, 12'd0, 3'd0, "call_oob");
        wr(5'd25, 12'd77, 1'b0, 12'd0, 3'd0, "wr_oob");
        rq(2'b00, 5'd0, 12'd0, 1'b1, 1'b0, 12'd0, 3'd0, "jump0_after_oob");
        rq(2'b00, 5'd3, 12'd0, 1'b1, 1'b0, 12'd196, 3'd0, "jump3_again");
        rq(2'b11, 5'd3, 12'd0, 1'b0, 1'b1, 12'd196, 3'd0, "op_rsvd");
        step(1'b0, 2'b00, 5'd3, 12'd0, 1'b0, '0, '0, 1'b0,
             1'b0, 1'b0, 12'd196, 3'd0, "idle_hold");

        rq(2'b01, 5'd3, 12'd200, 1'b1, 1'b0, 12'd196, 3'd1, "pre_rst_call1");
        rq(2'b01, 5'd3, 12'd300, 1'b1, 1'b0, 12'd196, 3'd2, "pre_rst_call2");
        Req = 1'b1; Op = 2'b01; Jptr = 5'd3; PC = 12'd400;
        #2;
        Reset = 1'b0;
        #1;
        chk_now("mid_reset", 1'b0, 1'b0, 12'd0, 3'd0);
        Req = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        rq(2'b10, 5'd0, 12'd0, 1'b0, 1'b1, 12'd0, 3'd0, "ret_after_reset");
        for (int i = 0; i < ENTRIES; i++) begin
            rq(2'b00, PTR_W'(i), PC_W'($urandom_range(1, 4095)),
               1'b1, 1'b0, 12'd0, 3'd0, $sformatf("cleared_%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/jlut_prog.md
Name: jlut_prog

Overview:
- Parametrised, run-time programmable successor to the fixed jump-target lookup table in the fetch stage.
- Holds ENTRIES branch targets, each tagged absolute or PC-relative, written by the loader/control path instead of being hard-coded.
- Serves JUMP, CALL and RET lookups with a registered 1-cycle result and an internal return-address stack, so the program counter logic gets subroutine support.

Parameters:
- PTR_W, 5, pointer width of table index.
- PC_W, 12, program counter / target width.
- ENTRIES, 32, number of table entries; must satisfy 1 <= ENTRIES <= 2**PTR_W.
- STACK_DEPTH, 4, return-address stack depth (>=1).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- WrEn  in  1  table write enable.
- WrPtr  in  PTR_W  table write index.
- WrData  in  PC_W  target (absolute) or signed offset (relative).
- WrMode  in  1  0 = absolute, 1 = relative.
- Req  in  1  lookup request.
- Op  in  2  00 JUMP, 01 CALL, 10 RET, 11 reserved.
- Jptr  in  PTR_W  lookup index (ignored for RET).
- PC  in  PC_W  PC of the requesting instruction.
- Valid  out  1  Jump is valid this cycle.
- Jump  out  PC_W  resolved target.
- Err  out  1  request rejected this cycle.
- Depth  out  $clog2(STACK_DEPTH+1)  current stack occupancy.

Behaviour:
- Reset (Reset=0, async):
  - All table entries clear to target 0, absolute mode.
  - Stack empty, Depth=0.
  - Valid=0, Err=0, Jump=0.
  - Reset asserted mid-operation discards any in-flight request; the first edge after release behaves as a fresh cycle.
- Write:
  - At a rising edge with WrEn=1 and WrPtr<ENTRIES, entry[WrPtr] <= {WrMode, WrData}.
  - WrPtr>=ENTRIES: the write is silently dropped.
- Lookup latency is exactly 1 cycle: inputs are sampled at edge N; Valid/Err/Jump update at edge N and are observed during cycle N+1.
- Req=0 at the edge: Valid<=0, Err<=0, Jump holds, stack unchanged.
- Write-first bypass: write and lookup to the same index at the same edge → the lookup uses the new WrData/WrMode.
- Entry resolution:
  - Absolute: T = entry.
  - Relative: T = (PC + entry) mod 2**PC_W, with entry treated as PC_W-bit two's complement. Wrap-around is silent, not an error.
- JUMP, Jptr<ENTRIES: Jump<=T, Valid<=1, Err<=0.
- CALL, Jptr<ENTRIES and Depth<STACK_DEPTH:
  - Jump<=T, Valid<=1.
  - Push (PC+1) mod 2**PC_W; Depth+1.
- CALL with stack full: Valid<=0, Err<=1, no push, Jump holds.
- RET, Depth>0: Jump<=top, Valid<=1, pop; Depth-1.
- RET with stack empty: Valid<=0, Err<=1, Jump holds.
- Jptr>=ENTRIES on JUMP/CALL, or Op=11: Valid<=0, Err<=1, no stack change.
- Valid and Err are never both 1.
- At most one stack operation per cycle. The stack is LIFO: push writes slot Depth, pop reads slot Depth-1; no wrap.
- Writes never affect the stack; stack state is unaffected by table contents after the push.

Test Plan:
- Reset, then Req JUMP Jptr=7 → next cycle Valid=1, Jump=0, Err=0, Depth=0.
- Write entry 3 = abs 196. JUMP Jptr=3 → Jump=196. Write entry 4 = rel 0xFFC (-4); JUMP Jptr=4 with PC=2 → Jump=0xFFE (wrap).
- Same edge: WrEn WrPtr=5 WrData=86 and Req JUMP Jptr=5 → next cycle Jump=86 (bypass).
- With entry1=abs 9, STACK_DEPTH=4: CALL Jptr=1 at PC=10,20,30,40 → Jump=9 each time, Depth=4. Fifth CALL → Err=1, Valid=0, Depth stays 4. Then four RETs → Jump=41,31,21,11, Depth=0. Fifth RET → Err=1.
- ENTRIES=20: JUMP Jptr=25 → Err=1, Valid=0. Write WrPtr=25 then JUMP Jptr=0 → Jump unaffected (0). Op=11 → Err=1.
- Two CALLs pushed, then Reset pulsed low mid-cycle → Valid=0, Jump=0, Depth=0 immediately. A subsequent RET → Err=1, and all entries read 0.
